oc_chipmon_drp_scheduler: RTL and testbench

Sits between the chip monitor's DRP port and its two users. It arbitrates DRP access between the host, which reaches the block through the CSR-to-DRP path, and an internal poller. The poller periodically reads temperature, VCCINT, VCCAUX and VCCBRAM and publishes the latest codes as plain outputs for throttling and telemetry logic. Only one DRP transaction is ever in flight, and every transaction is protected by a timeout.

---
 rtl/oclib_pkg.sv | 42 ++++
 rtl/oc_chipmon_poll_timer.sv | 28 ++
 rtl/oc_chipmon_drp_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_oc_chipmon_drp_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared DRP bus types plus chip-monitor register addresses, bus-owner tags and
// helpers used by the DRP scheduler.
package oclib_pkg;

  typedef struct packed {
    logic        enable;
    logic [7:0]  address;
    logic        write;
    logic [15:0] wdata;
  } drp_s;

  typedef struct packed {
    logic        ready;
    logic [15:0] rdata;
  } drp_fb_s;

  localparam logic [7:0] ChipMonDrpAddrTemp    = 8'h00;
  localparam logic [7:0] ChipMonDrpAddrVccInt  = 8'h01;
  localparam logic [7:0] ChipMonDrpAddrVccAux  = 8'h02;
  localparam logic [7:0] ChipMonDrpAddrVccBram = 8'h06;

  localparam logic [15:0] ChipMonAbortData = 16'hFFFF;

  typedef enum logic {OwnerHost, OwnerPoll} chipmon_drp_owner_e;

  typedef enum logic {StIdle, StWait} chipmon_drp_state_e;

  // Poll round order: temp, vccInt, vccAux, vccBram.
  function automatic logic [7:0] chipmon_poll_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ChipMonDrpAddrTemp;
      2'd1:    return ChipMonDrpAddrVccInt;
      2'd2:    return ChipMonDrpAddrVccAux;
      default: return ChipMonDrpAddrVccBram;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/oc_chipmon_poll_timer.sv
// Free-running down-counter that emits a 1-cycle tick every PollCycles clocks.
module oc_chipmon_poll_timer
  import oclib_pkg::*;
#(
  parameter int unsigned PollCycles = 100_000
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(PollCycles);
  localparam logic [CntW-1:0] CntLoad = CntW'(PollCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? CntLoad : cnt_q - 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= CntLoad;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/oc_chipmon_drp_scheduler.sv
// Arbitrates the chip-monitor DRP port between host requests and a periodic sensor
// poller, with one transaction in flight and a per-transaction timeout.
module oc_chipmon_drp_scheduler
  import oclib_pkg::*;
#(
  parameter int unsigned ClockHz       = 100_000_000,
  parameter int unsigned PollPeriodUs  = 1000,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  drp_s        hostDrp,
  output drp_fb_s     hostDrpFb,
  output drp_s        drp,
  input  drp_fb_s     drpFb,
  input  logic        pollEnable,
  output logic [15:0] temp,
  output logic [15:0] vccInt,
  output logic [15:0] vccAux,
  output logic [15:0] vccBram,
  output logic        sensorValid,
  output logic        pollDone,
  output logic [7:0]  timeoutCount,
  output logic        protocolError
);

  localparam int unsigned PollCycles  = (ClockHz / 1_000_000) * PollPeriodUs;
  localparam logic [15:0] TimeoutLoad = 16'(TimeoutCycles - 1);

  chipmon_drp_state_e state_q, state_d;
  chipmon_drp_owner_e owner_q, owner_d;

  logic              host_pend_q, host_pend_d;
  logic [7:0]        host_addr_q, host_addr_d;
  logic              host_write_q, host_write_d;
  logic [15:0]       host_wdata_q, host_wdata_d;
  logic [7:0]        drp_addr_q, drp_addr_d;
  logic              drp_write_q, drp_write_d;
  logic [15:0]       drp_wdata_q, drp_wdata_d;
  logic              drp_en;
  logic [15:0]       tmo_q, tmo_d;
  logic              round_q, round_d;
  logic [1:0]        idx_q, idx_d;
  logic              poll_pend_q, poll_pend_d;
  logic [3:0][15:0]  sens_q, sens_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        tcount_q, tcount_d;
  logic              perr_q, perr_d;
  drp_fb_s           hfb_q, hfb_d;
  logic              finish_poll;
  logic              tick;

  oc_chipmon_poll_timer #(
    .PollCycles(PollCycles)
  ) u_poll_timer (
    .clock_i(clock),
    .reset_i(reset),
    .tick_o (tick)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    host_pend_d  = host_pend_q;
    host_addr_d  = host_addr_q;
    host_write_d = host_write_q;
    host_wdata_d = host_wdata_q;
    drp_addr_d   = drp_addr_q;
    drp_write_d  = drp_write_q;
    drp_wdata_d  = drp_wdata_q;
    drp_en       = 1'b0;
    tmo_d        = tmo_q;
    round_d      = round_q;
    idx_d        = idx_q;
    poll_pend_d  = poll_pend_q;
    sens_d       = sens_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    tcount_d     = tcount_q;
    perr_d       = perr_q;
    hfb_d        = '0;
    finish_poll  = 1'b0;

    // A host request is still outstanding until its response has been returned.
    if (hostDrp.enable) begin
      if (host_pend_q || (state_q == StWait && owner_q == OwnerHost)) begin
        perr_d = 1'b1;
      end else begin
        host_pend_d  = 1'b1;
        host_addr_d  = hostDrp.address;
        host_write_d = hostDrp.write;
        host_wdata_d = hostDrp.wdata;
      end
    end

    if (tick && pollEnable && !round_q) begin
      round_d     = 1'b1;
      idx_d       = 2'd0;
      poll_pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (host_pend_q) begin
          drp_en      = 1'b1;
          owner_d     = OwnerHost;
          host_pend_d = 1'b0;
          drp_addr_d  = host_addr_q;
          drp_write_d = host_write_q;
          drp_wdata_d = host_wdata_q;
          tmo_d       = TimeoutLoad;
          state_d     = StWait;
        end else if (poll_pend_q) begin
          drp_en      = 1'b1;
          owner_d     = OwnerPoll;
          poll_pend_d = 1'b0;
          drp_addr_d  = chipmon_poll_addr(idx_q);
          drp_write_d = 1'b0;
          drp_wdata_d = 16'h0000;
          tmo_d       = TimeoutLoad;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (drpFb.ready) begin
          state_d = StIdle;
          if (owner_q == OwnerHost) begin
            hfb_d = '{ready: 1'b1, rdata: drpFb.rdata};
          end else begin
            sens_d[idx_q] = drpFb.rdata;
            finish_poll   = 1'b1;
          end
        end else if (tmo_q == 16'd0) begin
          state_d  = StIdle;
          tcount_d = sat_inc8(tcount_q);
          if (owner_q == OwnerHost) hfb_d = '{ready: 1'b1, rdata: ChipMonAbortData};
          else                      finish_poll = 1'b1;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish_poll) begin
      if (idx_q == 2'd3) begin
        round_d = 1'b0;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end else begin
        idx_d       = idx_q + 2'd1;
        poll_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerHost;
      host_pend_q  <= 1'b0;
      host_addr_q  <= '0;
      host_write_q <= 1'b0;
      host_wdata_q <= '0;
      drp_addr_q   <= '0;
      drp_write_q  <= 1'b0;
      drp_wdata_q  <= '0;
      tmo_q        <= '0;
      round_q      <= 1'b0;
      idx_q        <= '0;
      poll_pend_q  <= 1'b0;
      sens_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      tcount_q     <= '0;
      perr_q       <= 1'b0;
      hfb_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      host_pend_q  <= host_pend_d;
      host_addr_q  <= host_addr_d;
      host_write_q <= host_write_d;
      host_wdata_q <= host_wdata_d;
      drp_addr_q   <= drp_addr_d;
      drp_write_q  <= drp_write_d;
      drp_wdata_q  <= drp_wdata_d;
      tmo_q        <= tmo_d;
      round_q      <= round_d;
      idx_q        <= idx_d;
      poll_pend_q  <= poll_pend_d;
      sens_q       <= sens_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      tcount_q     <= tcount_d;
      perr_q       <= perr_d;
      hfb_q        <= hfb_d;
    end
  end

  // Address/data come from the next-state view so the grant cycle already shows them.
  assign drp           = '{enable: drp_en, address: drp_addr_d, write: drp_write_d, wdata: drp_wdata_d};
  assign hostDrpFb     = hfb_q;
  assign temp          = sens_q[0];
  assign vccInt        = sens_q[1];
  assign vccAux        = sens_q[2];
  assign vccBram       = sens_q[3];
  assign sensorValid   = valid_q;
  assign pollDone      = done_q;
  assign timeoutCount  = tcount_q;
  assign protocolError = perr_q;

endmodule

// File: tb/tb_oc_chipmon_drp_scheduler.sv
// Directed bench for the chip-monitor DRP scheduler with a simple DRP responder model.
module tb_oc_chipmon_drp_scheduler;
  import oclib_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  drp_s        hostDrp;
  drp_fb_s     hostDrpFb;
  drp_s        drp;
  drp_fb_s     drpFb;
  logic        pollEnable;
  logic [15:0] temp, vccInt, vccAux, vccBram;
  logic        sensorValid, pollDone, protocolError;
  logic [7:0]  timeoutCount;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  oc_chipmon_drp_scheduler #(
    .ClockHz      (100_000_000),
    .PollPeriodUs (1),
    .TimeoutCycles(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hostDrp      (hostDrp),
    .hostDrpFb    (hostDrpFb),
    .drp          (drp),
    .drpFb        (drpFb),
    .pollEnable   (pollEnable),
    .temp         (temp),
    .vccInt       (vccInt),
    .vccAux       (vccAux),
    .vccBram      (vccBram),
    .sensorValid  (sensorValid),
    .pollDone     (pollDone),
    .timeoutCount (timeoutCount),
    .protocolError(protocolError)
  );

  // Responder: answers each enable after m_delay cycles with address-dependent data.
  int          m_delay   = 3;
  logic        m_resp_en = 1'b1;
  logic        m_busy    = 1'b0;
  int          m_cnt     = 0;
  logic        m_rdy     = 1'b0;
  logic [15:0] m_data    = 16'h0;
  logic        inj_rdy   = 1'b0;
  logic [15:0] inj_data  = 16'h0;

  function automatic logic [15:0] model_data(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hA5A5;
      8'h01:   return 16'h1111;
      8'h02:   return 16'h2222;
      8'h06:   return 16'h6666;
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clock) begin
    m_rdy <= 1'b0;
    if (drp.enable) begin
      if (m_resp_en) begin
        m_busy <= 1'b1;
        m_cnt  <= m_delay - 1;
        m_data <= model_data(drp.address);
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    drpFb.ready = m_rdy | inj_rdy;
    drpFb.rdata = inj_rdy ? inj_data : m_data;
  end

  int         en_cnt  = 0;
  int         hfb_cnt = 0;
  logic [7:0] addr_log[$];

  always @(posedge clock) begin
    if (drp.enable) begin
      en_cnt <= en_cnt + 1;
      addr_log.push_back(drp.address);
    end
    if (hostDrpFb.ready) hfb_cnt <= hfb_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_req(input logic [7:0] a);
    hostDrp = '{enable: 1'b1, address: a, write: 1'b0, wdata: 16'h0};
    step(1);
    hostDrp = '0;
  endtask

  task automatic wait_hready(input int maxc, input logic [15:0] exp, input string tag,
                             output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (hostDrpFb.ready) begin
        seen = 1'b1;
        lat  = i + 1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_data"}, 64'(hostDrpFb.rdata), 64'(exp));
  endtask

  task automatic wait_done(input int maxc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (pollDone) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int lat;
    int c0;
    bit seen;
    hostDrp    = '0;
    pollEnable = 1'b0;

    // Reset state
    step(2);
    check("rst_drp", 64'(drp), 64'h0);
    check("rst_hfb", 64'(hostDrpFb), 64'h0);
    check("rst_sens", {temp, vccInt, vccAux, vccBram}, 64'h0);
    check("rst_flags", 64'({sensorValid, pollDone, protocolError}), 64'h0);
    check("rst_tcnt", 64'(timeoutCount), 64'h0);
    reset = 1'b0;
    step(2);

    // Host read, responder answers 3 cycles after enable
    host_req(8'h00);
    check("h_en", 64'(drp.enable), 64'd1);
    check("h_addr", 64'(drp.address), 64'h00);
    check("h_wr", 64'(drp.write), 64'd0);
    step(1);
    check("h_en_off", 64'(drp.enable), 64'd0);
    check("h_addr_hold", 64'(drp.address), 64'h00);
    step(2);
    check("h_rdy_early", 64'(hostDrpFb.ready), 64'd0);
    step(1);
    check("h_rdy", 64'(hostDrpFb.ready), 64'd1);
    check("h_rdata", 64'(hostDrpFb.rdata), 64'hA5A5);
    step(1);
    check("h_rdy_pulse", 64'(hostDrpFb.ready), 64'd0);

    // Second enable while the first is pending
    m_delay = 5;
    c0 = en_cnt;
    host_req(8'h01);
    hostDrp = '{enable: 1'b1, address: 8'h02, write: 1'b0, wdata: 16'h0};
    step(1);
    hostDrp = '0;
    wait_hready(20, 16'h1111, "perr_rd", lat);
    step(3);
    check("perr_flag", 64'(protocolError), 64'd1);
    check("perr_one_en", 64'(en_cnt - c0), 64'd1);

    // Timeout: no response at all
    m_resp_en = 1'b0;
    host_req(8'h00);
    wait_hready(20, 16'hFFFF, "tmo", lat);
    check("tmo_lat", 64'(lat), 64'd9);
    check("tmo_cnt1", 64'(timeoutCount), 64'd1);
    step(1);
    c0 = hfb_cnt;
    inj_data = 16'h1234;
    inj_rdy  = 1'b1;
    step(1);
    inj_rdy  = 1'b0;
    step(2);
    check("late_no_rdy", 64'(hfb_cnt - c0), 64'd0);
    check("late_tcnt", 64'(timeoutCount), 64'd1);
    check("late_sens", {temp, vccInt, vccAux, vccBram}, 64'h0);
    for (int k = 0; k < 299; k++) begin
      host_req(8'h00);
      step(9);
    end
    step(2);
    check("tmo_sat", 64'(timeoutCount), 64'd255);
    m_resp_en = 1'b1;
    m_delay   = 3;
    step(2);

    // Full poll round
    addr_log.delete();
    pollEnable = 1'b1;
    wait_done(300, "poll1");
    check("poll1_n", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() >= 4)
      check("poll1_order", 64'({addr_log[0], addr_log[1], addr_log[2], addr_log[3]}), 64'h00010206);
    check("poll1_sens", {temp, vccInt, vccAux, vccBram}, 64'hA5A5_1111_2222_6666);
    check("poll1_valid", 64'(sensorValid), 64'd1);
    step(1);
    check("poll1_pulse", 64'(pollDone), 64'd0);

    // Host request during poll WAIT, pollEnable dropped mid-round
    addr_log.delete();
    c0 = en_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (en_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    check("ilv_start", 64'(seen), 64'd1);
    host_req(8'h02);
    pollEnable = 1'b0;
    wait_hready(20, 16'h2222, "ilv_host", lat);
    wait_done(100, "ilv");
    check("ilv_n", 64'(addr_log.size()), 64'd5);
    if (addr_log.size() >= 5)
      check("ilv_order", 64'({addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[4]}),
            64'h00_02_01_02_06);
    check("ilv_sens", {temp, vccInt, vccAux, vccBram}, 64'hA5A5_1111_2222_6666);
    step(2);

    // Reset while a host transaction is in flight
    m_delay = 6;
    host_req(8'h01);
    check("rw_en", 64'(drp.enable), 64'd1);
    step(1);
    reset = 1'b1;
    c0 = hfb_cnt;
    step(1);
    check("rw_drp", 64'(drp), 64'h0);
    check("rw_hfb", 64'(hostDrpFb), 64'h0);
    check("rw_sens", {temp, vccInt, vccAux, vccBram}, 64'h0);
    check("rw_flags", 64'({sensorValid, pollDone, protocolError}), 64'h0);
    check("rw_tcnt", 64'(timeoutCount), 64'h0);
    step(1);
    reset = 1'b0;
    step(8);
    check("rw_no_resp", 64'(hfb_cnt - c0), 64'd0);
    m_delay = 3;
    host_req(8'h06);
    wait_hready(10, 16'h6666, "post_rst", lat);
    check("post_rst_lat", 64'(lat), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
